// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/grant/response bus between the fetch sequencer and imem.
// One response is returned per granted request; only one request is ever outstanding.
interface fetch_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Owns the architectural PC, fetches one instruction at a time from imem, holds it
// for decode under stall, applies execute redirects and drops stale responses.
module fetch_sequencer #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    TIMEOUT      = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redir_valid,
    input  logic [DATA_WIDTH-1:0] redir_target,
    fetch_sequencer_if.master     imem,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pcplus4,
    output logic                  flush,
    output logic                  fetch_err
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t        state;
    logic          drop;
    logic [CW-1:0] wait_cnt;

    assign imem.imem_req  = (state == S_REQ);
    assign imem.imem_addr = pc;
    assign pcplus4        = pc + DATA_WIDTH'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_VECTOR;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            flush       <= 1'b0;
            fetch_err   <= 1'b0;
            drop        <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            // NOTE: defaults first; a later non-blocking assignment in this block overrides them.
            flush <= 1'b0;
            if (instr_valid && !stall) begin
                instr_valid <= 1'b0;
            end

            if (redir_valid && state != S_ERR) begin
                if (redir_target[1:0] != 2'b00) begin
                    fetch_err   <= 1'b1;
                    instr_valid <= 1'b0;
                    drop        <= 1'b0;
                    state       <= S_ERR;
                end else begin
                    pc          <= redir_target;
                    instr_valid <= 1'b0;
                    flush       <= 1'b1;
                    // The in-flight response still has to arrive; remember to discard it.
                    if (state == S_WAIT && !imem.imem_rvalid) begin
                        drop  <= 1'b1;
                        state <= S_WAIT;
                        if (wait_cnt != CNT_MAX) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        drop  <= 1'b0;
                        state <= S_REQ;
                    end
                end
            end else begin
                unique case (state)
                    S_REQ: begin
                        if (imem.imem_gnt) begin
                            wait_cnt <= '0;
                            state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem.imem_rvalid) begin
                            if (drop) begin
                                drop  <= 1'b0;
                                state <= S_REQ;
                            end else begin
                                instr       <= imem.imem_rdata;
                                instr_pc    <= pc;
                                instr_valid <= 1'b1;
                                pc          <= pcplus4;
                                state       <= stall ? S_HOLD : S_REQ;
                            end
                        end else if (wait_cnt >= CNT_LAST) begin
                            fetch_err   <= 1'b1;
                            instr_valid <= 1'b0;
                            state       <= S_ERR;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            instr_valid <= 1'b0;
                            state       <= S_REQ;
                        end
                    end
                    S_ERR: begin
                        instr_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised and directed stimulus for fetch_sequencer, compared every cycle against a
// transaction-level reference model and a single-outstanding imem responder.
module tb_fetch_sequencer;

    localparam int          DW      = 32;
    localparam int          TIMEOUT = 15;
    localparam logic [31:0] RV      = 32'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          redir_valid;
    logic [DW-1:0] redir_target;
    logic [DW-1:0] instr;
    logic [DW-1:0] instr_pc;
    logic          instr_valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] pcplus4;
    logic          flush;
    logic          fetch_err;

    fetch_sequencer_if #(.DATA_WIDTH(DW)) imem_bus ();

    fetch_sequencer #(
        .DATA_WIDTH  (DW),
        .RESET_VECTOR(RV),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_target(redir_target),
        .imem        (imem_bus),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pcplus4     (pcplus4),
        .flush       (flush),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what decode and imem should see, derived from transaction rules.
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_valid, m_flush, m_err;
    bit          m_busy;      // a granted response is still expected by the fetcher
    bit          m_drop;      // that response must be thrown away
    bit          m_blocked;   // captured instruction waiting for decode to unstall
    int          m_waited;

    // imem responder: one outstanding request, data is a fixed function of the address.
    bit          mem_pending;
    int          mem_wait;
    logic [31:0] mem_data;
    bit          hold_rvalid;
    int          gnt_pct, lat_min, lat_max;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic model_step(input bit g, input bit rv, input logic [31:0] rd);
        bit captured;
        captured = 1'b0;
        m_flush  = 1'b0;
        if (rst) begin
            m_pc = RV; m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_err = 1'b0;
            m_busy = 1'b0; m_drop = 1'b0; m_blocked = 1'b0; m_waited = 0;
            return;
        end
        if (m_err) return;
        if (redir_valid) begin
            if (redir_target[1:0] != 2'b00) begin
                m_err = 1'b1; m_valid = 1'b0; m_busy = 1'b0; m_drop = 1'b0; m_blocked = 1'b0;
                return;
            end
            m_pc = redir_target; m_valid = 1'b0; m_flush = 1'b1; m_blocked = 1'b0;
            if (m_busy) begin
                m_waited++;
                if (rv) begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end
            return;
        end
        if (m_busy) begin
            m_waited++;
            if (rv) begin
                m_busy = 1'b0;
                if (m_drop) begin
                    m_drop = 1'b0;
                end else begin
                    captured  = 1'b1;
                    m_instr   = rd;
                    m_ipc     = m_pc;
                    m_pc      = m_pc + 32'd4;
                    m_blocked = stall;
                end
            end else if (m_waited >= TIMEOUT) begin
                m_err = 1'b1; m_busy = 1'b0; m_valid = 1'b0;
                return;
            end
        end else if (m_blocked) begin
            if (!stall) m_blocked = 1'b0;
        end else if (g) begin
            m_busy   = 1'b1;
            m_waited = 0;
        end
        if (captured) m_valid = 1'b1;
        else if (!stall) m_valid = 1'b0;
    endtask

    task automatic check_outputs();
        bit exp_req;
        exp_req = !m_err && !m_busy && !m_blocked;
        check("pc", pc, m_pc);
        check("pcplus4", pcplus4, m_pc + 32'd4);
        check("imem_req", {31'b0, imem_bus.imem_req}, {31'b0, exp_req});
        if (exp_req) check("imem_addr", imem_bus.imem_addr, m_pc);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_ipc);
        check("flush", {31'b0, flush}, {31'b0, m_flush});
        check("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
    endtask

    // Drive imem for the coming edge, advance the model, then sample at the falling edge.
    task automatic cycle();
        bit          g, rv;
        logic [31:0] rd;
        g  = 1'b0;
        rv = 1'b0;
        rd = $urandom;
        if (mem_pending) begin
            if (mem_wait <= 1) begin
                if (!hold_rvalid) begin
                    rv = 1'b1;
                    rd = mem_data;
                    mem_pending = 1'b0;
                end
            end else begin
                mem_wait--;
            end
        end else if (!rst && imem_bus.imem_req === 1'b1 && int'($urandom_range(99)) < gnt_pct) begin
            g           = 1'b1;
            mem_pending = 1'b1;
            mem_wait    = int'($urandom_range(lat_max, lat_min));
            mem_data    = mem_word(imem_bus.imem_addr);
        end
        imem_bus.imem_gnt    = g;
        imem_bus.imem_rvalid = rv;
        imem_bus.imem_rdata  = rd;
        model_step(g, rv, rd);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_req_addr(input logic [31:0] a);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (imem_bus.imem_req === 1'b1 && imem_bus.imem_addr === a) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        check("reach_addr", {31'b0, found}, 32'd1);
    endtask

    task automatic redirect(input logic [31:0] t);
        redir_valid  = 1'b1;
        redir_target = t;
        cycle();
        redir_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = '0;
        imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; hold_rvalid = 1'b0;
        mem_pending = 1'b0; mem_wait = 0; mem_data = '0;
        m_pc = RV; m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_flush = 1'b0; m_err = 1'b0;
        m_busy = 1'b0; m_drop = 1'b0; m_blocked = 1'b0; m_waited = 0;

        // Straight-line fetch 0,4,8,C with immediate grant and 1-cycle response.
        run(2);
        rst = 1'b0;
        run(12);

        // Capture at 8 under a 3-cycle stall, then resume with a request for 0xC.
        rst = 1'b1; cycle(); rst = 1'b0;
        wait_req_addr(32'h8);
        cycle();
        stall = 1'b1;
        run(3);
        stall = 1'b0;
        run(1);

        // Redirect while waiting on 0x10; its response arrives two cycles later.
        lat_min = 3; lat_max = 3;
        wait_req_addr(32'h10);
        cycle();
        redirect(32'h100);
        run(2);

        // Redirect coincident with the response.
        lat_min = 2; lat_max = 2;
        wait_req_addr(32'h104);
        cycle();
        cycle();
        redirect(32'h200);

        // Redirect while holding a stalled instruction.
        lat_min = 1; lat_max = 1;
        wait_req_addr(32'h208);
        cycle();
        stall = 1'b1;
        run(2);
        redirect(32'h300);
        stall = 1'b0;
        run(4);

        // Misaligned redirect: error is sticky, later redirects ignored, reset recovers.
        redirect(32'h102);
        run(3);
        redirect(32'h40);
        run(3);
        rst = 1'b1; cycle(); rst = 1'b0;
        run(6);

        // Response withheld past the timeout, then reset with the late response still due.
        hold_rvalid = 1'b1;
        run(TIMEOUT + 4);
        rst = 1'b1; cycle(); rst = 1'b0;
        hold_rvalid = 1'b0;
        run(6);

        // PC wraps from the top of the address space.
        redirect(32'hFFFF_FFFC);
        run(10);

        // Random traffic: variable grant/latency, stalls, redirects and occasional resets.
        gnt_pct = 60; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] r;
            stall       = (int'($urandom_range(99)) < 30);
            redir_valid = 1'b0;
            rst         = 1'b0;
            if (m_err) rst = (int'($urandom_range(99)) < 20);
            else if (int'($urandom_range(999)) < 5) rst = 1'b1;
            if (int'($urandom_range(99)) < 6) begin
                r           = $urandom;
                redir_valid = 1'b1;
                case ($urandom_range(9))
                    0:       redir_target = r | 32'h1;
                    1:       redir_target = 32'hFFFF_FFF0 | (r & 32'hC);
                    default: redir_target = r & ~32'h3;
                endcase
            end
            cycle();
        end
        rst = 1'b0; stall = 1'b0; redir_valid = 1'b0;
        run(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the architectural PC and sequences instruction fetch over a request/grant/response handshake to instruction memory.
- Holds a fetched instruction under decode stall.
- Applies redirects from execute (branch/JAL/JALR targets already resolved) and discards stale in-flight responses.
- Sits between instruction memory and the decode stage; the hazard unit drives its stall input.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction word
- RESET_VECTOR, 32'h0, PC value loaded on reset
- TIMEOUT, 15, maximum cycles in WAIT before a fetch error; counter width is $clog2(TIMEOUT+1)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- stall  in  1  decode cannot accept an instruction this cycle
- redir_valid  in  1  execute requests a PC redirect this cycle
- redir_target  in  DATA_WIDTH  redirect destination
- imem_req  out  1  fetch request valid
- imem_addr  out  DATA_WIDTH  fetch address; equals pc while imem_req=1
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response valid, one per granted request
- imem_rdata  in  DATA_WIDTH  response instruction
- instr  out  DATA_WIDTH  instruction presented to decode
- instr_pc  out  DATA_WIDTH  address of instr
- instr_valid  out  1  instr/instr_pc valid
- pc  out  DATA_WIDTH  current fetch PC
- pcplus4  out  DATA_WIDTH  pc+4, combinational, truncated to DATA_WIDTH
- flush  out  1  one-cycle pulse, registered, the cycle after a redirect is accepted
- fetch_err  out  1  sticky error flag; cleared only by rst

Behaviour:
- Reset (rst=1 at posedge; overrides all other inputs):
  - pc=RESET_VECTOR, state=REQ, instr=0, instr_pc=0, instr_valid=0, flush=0, fetch_err=0, drop=0, timeout counter=0.
  - imem_req is decoded from state and is 1 in the first cycle after reset.
- States: REQ, WAIT, HOLD, ERR.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_gnt: go to WAIT and clear the timeout counter.
  - Without a grant, the request and address are held stable.
- WAIT:
  - imem_req=0; the counter increments each cycle.
  - On imem_rvalid with drop=0: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4.
    - If stall=0 in the capture cycle, go to REQ.
    - Otherwise go to HOLD.
  - On imem_rvalid with drop=1: discard the data, clear drop, go to REQ (pc is already the redirect target).
  - If the counter reaches TIMEOUT without rvalid: fetch_err<=1, go to ERR.
- HOLD:
  - instr, instr_pc and instr_valid are held; no request is issued.
  - When stall=0: instr_valid<=0, go to REQ.
- Consumption: decode consumes an instruction in any cycle where instr_valid=1 and stall=0. instr_valid clears the next cycle unless a new capture occurs in that same cycle.
- ERR: imem_req=0, instr_valid=0. Redirects are ignored. Exit only via rst.
- Redirect (redir_valid=1, state not ERR):
  - If redir_target[1:0]!=0: fetch_err<=1, go to ERR, no flush.
  - Otherwise: pc<=redir_target, instr_valid<=0, flush<=1 for exactly one cycle.
  - From REQ (granted or not) or HOLD: go to REQ.
  - From WAIT: set drop=1 and stay in WAIT. If imem_rvalid arrives in the same cycle as the redirect, that response is discarded and the state goes directly to REQ with drop=0.
- Priority: rst > redirect > response/grant > stall.
- Redirect vs. stall: a redirect is honoured even when stall=1.
- Arithmetic: all PC adds wrap modulo 2^DATA_WIDTH. pc=32'hFFFF_FFFC advances to 32'h0000_0000 with no error.
- Back-to-back redirects each produce their own flush pulse; the last target wins.
- Reset mid-fetch: an outstanding memory response arriving after rst is ignored by the following rule:
  - imem_rvalid is ignored in REQ, HOLD and ERR.

Test Plan:
- Reset, imem grants immediately with 1-cycle rvalid, stall=0 -> imem_addr sequence 0,4,8,C; instr_pc matches; instr_valid pulses once per fetch; flush never asserts.
- Capture at instr_pc=8 with stall held 3 cycles -> instr/instr_pc stable 3 cycles, no imem_req; req for 0xC one cycle after stall drops.
- Redirect to 0x100 while in WAIT for 0x10, rvalid two cycles later -> flush pulses once, stale data never shows instr_valid, next imem_addr=0x100.
- Redirect to 0x200 coincident with rvalid, and separately redirect during HOLD -> both discard/invalidate; next request at 0x200; single flush each.
- Redirect to 0x102 -> fetch_err=1, state ERR, no requests; later valid redirect ignored; rst clears everything and refetches RESET_VECTOR.
- Withhold rvalid for TIMEOUT cycles -> fetch_err=1. Start at pc=0xFFFFFFFC -> next address 0x0, no error.
